// File: rtl/regfile_writeback_queue.sv
// regfile_writeback_queue: in-order write-back buffer feeding the register-file RAM write port
// Ports: iClk/iRst_n clock and synchronous active-low reset; iWrValid/iWrAddr/iWrData/oWrReady
// write-back handshake; iPortBusy blocks the drain; oRamEn/oRamWe/oRamAddr/oRamData registered
// RAM write port; iLookupAddr/oHit/oHitData forwarding lookup; oCount/oEmpty occupancy.
module regfile_writeback_queue #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int DEPTH = 4
) (
  input  logic                      iClk,
  input  logic                      iRst_n,
  input  logic                      iWrValid,
  input  logic [ADDR_WIDTH-1:0]     iWrAddr,
  input  logic [DATA_WIDTH-1:0]     iWrData,
  output logic                      oWrReady,
  input  logic                      iPortBusy,
  output logic                      oRamEn,
  output logic                      oRamWe,
  output logic [ADDR_WIDTH-1:0]     oRamAddr,
  output logic [DATA_WIDTH-1:0]     oRamData,
  input  logic [ADDR_WIDTH-1:0]     iLookupAddr,
  output logic                      oHit,
  output logic [DATA_WIDTH-1:0]     oHitData,
  output logic [$clog2(DEPTH):0]    oCount,
  output logic                      oEmpty
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  logic [ADDR_WIDTH-1:0] q_addr [DEPTH];
  logic [DATA_WIDTH-1:0] q_data [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr, idx;
  logic [CW-1:0] count;
  logic push, pop;
  assign oWrReady = count != CW'(DEPTH);
  assign oCount = count;
  assign oEmpty = count == '0;
  // writes to r0 complete the handshake but never occupy an entry
  assign push = iWrValid && oWrReady && iWrAddr != '0;
  assign pop = count != '0 && !iPortBusy;
  always_ff @(posedge iClk) begin
    if (!iRst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      oRamEn <= 1'b0;
      oRamWe <= 1'b0;
      oRamAddr <= '0;
      oRamData <= '0;
    end else begin
      count <= count + CW'(push) - CW'(pop);
      oRamEn <= pop;
      oRamWe <= pop;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
        oRamAddr <= q_addr[rd_ptr];
        oRamData <= q_data[rd_ptr];
      end
    end
  end
  always_ff @(posedge iClk) begin
    if (push) begin
      q_addr[wr_ptr] <= iWrAddr;
      q_data[wr_ptr] <= iWrData;
    end
  end
  // the in-flight entry is checked first so any queued match (always younger) overrides it;
  // queue entries are walked oldest to youngest so the youngest match wins
  always_comb begin
    oHit = 1'b0;
    oHitData = '0;
    idx = '0;
    if (oRamWe && oRamAddr == iLookupAddr) begin
      oHit = 1'b1;
      oHitData = oRamData;
    end
    for (int i = 0; i < DEPTH; i++) begin
      idx = rd_ptr + PW'(i);
      if (CW'(i) < count && q_addr[idx] == iLookupAddr) begin
        oHit = 1'b1;
        oHitData = q_data[idx];
      end
    end
    if (iLookupAddr == '0) begin
      oHit = 1'b0;
      oHitData = '0;
    end
  end
endmodule

// File: doc/regfile_writeback_queue.md
Name: regfile_writeback_queue

Overview:
- Small write-back buffer sitting directly upstream of the register-file dual-port RAM write port.
- Accepts register writes from the pipeline write-back stage and queues them in order.
- Drains one entry per cycle into the RAM port whenever the port is not claimed by a read.
- Provides a forwarding lookup so operand reads see pending (not yet committed) writes.

Parameters:
- DATA_WIDTH, 32, register data width; matches the RAM data width.
- ADDR_WIDTH, 5, register address width; matches the RAM address width.
- DEPTH, 4, number of queue entries; must be a power of 2 and at least 2.

Ports:
- iClk  input  1  single clock; all state updates on its rising edge.
- iRst_n  input  1  synchronous, active-low reset, sampled on the rising edge of iClk.
- iWrValid  input  1  write-back request valid.
- iWrAddr  input  ADDR_WIDTH  destination register.
- iWrData  input  DATA_WIDTH  write data.
- oWrReady  output  1  queue can accept; equals not-full.
- iPortBusy  input  1  RAM port claimed by a read this cycle; blocks the drain.
- oRamEn  output  1  RAM port enable (drives iEnX).
- oRamWe  output  1  RAM write enable (drives iWeX).
- oRamAddr  output  ADDR_WIDTH  RAM address.
- oRamData  output  DATA_WIDTH  RAM write data.
- iLookupAddr  input  ADDR_WIDTH  forwarding lookup address.
- oHit  output  1  a pending write to iLookupAddr exists.
- oHitData  output  DATA_WIDTH  data of the youngest pending write to iLookupAddr.
- oCount  output  $clog2(DEPTH)+1  number of queued entries.
- oEmpty  output  1  oCount == 0.

Behaviour:
- Reset (iRst_n low at a rising edge):
  - Read/write pointers and oCount go to 0; all queued entries are discarded.
  - oRamEn, oRamWe, oRamAddr and oRamData go to 0.
  - After reset, oWrReady = 1 and oEmpty = 1.
  - Reset mid-operation drops pending writes without committing them; oRamWe is 0 after that edge.
- Enqueue:
  - Occurs at a rising edge when iWrValid && oWrReady.
  - The entry is written at the write pointer, and the write pointer increments modulo DEPTH.
  - iWrAddr == 0 is accepted (handshake completes) but discarded: no entry is written and oCount is unchanged. Register 0 is hardwired zero.
- Drain:
  - Occurs at a rising edge when oCount > 0 && !iPortBusy.
  - The head entry is registered onto oRamAddr/oRamData with oRamEn = oRamWe = 1 for exactly that one cycle.
  - The read pointer increments modulo DEPTH.
  - Otherwise oRamEn = oRamWe = 0, and oRamAddr/oRamData hold their last values.
  - The RAM commits on the following falling edge.
- Latency:
  - An entry accepted at edge N drives oRamWe high at the earliest after edge N+1.
  - There is no bypass from iWr* to oRam*.
- Simultaneous enqueue and drain:
  - oCount is unchanged and both pointers advance.
  - When full, oWrReady = 0 even if a drain occurs the same cycle; no combinational ready-through-drain path.
- oCount and pointers:
  - oCount is incremented/decremented in one adder.
  - It never exceeds DEPTH and never goes below 0.
  - Pointers are ADDR bits of $clog2(DEPTH) and wrap naturally.
- Lookup (combinational):
  - Compares iLookupAddr against all valid queue entries and against the in-flight output register (when oRamWe = 1).
  - Priority: youngest queue entry first, then older queue entries, then the in-flight entry. The in-flight entry is included because a same-edge RAM read returns old data.
  - iLookupAddr == 0 never hits.
  - On a miss, oHitData = 0.
  - Same-cycle iWr* does not affect oHit.
- Ordering: strictly FIFO; multiple pending writes to the same address are all committed in order.

Test Plan:
- Reset, then single write: write r5 = 0xDEADBEEF at edge 1 with iPortBusy = 0 -> oRamWe = 1, oRamAddr = 5, oRamData = 0xDEADBEEF after edge 2; oCount = 0 after edge 2.
- Fill: iPortBusy = 1, write r1..r4 = 0x11..0x44 -> oCount = 4, oWrReady = 0. A fifth write is not accepted. Release busy -> four consecutive oRamWe pulses with addr 1,2,3,4 in order.
- Forwarding priority: iPortBusy = 1, queue r7 = 0xA then r7 = 0xB, lookup r7 -> oHit = 1, oHitData = 0xB. While the 0xB entry sits in the output register (queue empty), the lookup still hits with 0xB; the next cycle oHit = 0.
- r0 discard: write r0 = 0xFFFFFFFF -> oWrReady = 1, oCount stays 0, no oRamWe pulse, lookup r0 gives oHit = 0.
- Simultaneous enqueue and drain at oCount = 2 across a pointer wrap (DEPTH = 4, after 3 prior pops) -> oCount stays 2, order preserved.
- Reset mid-operation with oCount = 3 -> after the reset edge oCount = 0, oRamWe = 0, oHit = 0, and no queued entry is ever driven to the RAM.
